// File: rtl/clint_mi.sv
// clint_mi: multi-source interrupt arbiter and trap CSR sequencer.
// Define CLINT_VECTORED_EN for vectored async trap targets.
module clint_mi #(
  parameter int INT_NUM = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  ins_i,
  input  logic [ADDR_W-1:0]  ins_addr_i,
  input  logic               restart_i,
  input  logic [INT_NUM-1:0] int_flag_i,
  input  logic [INT_NUM-1:0] int_mask_i,
  input  logic [DATA_W-1:0]  csr_mtvec,
  input  logic [DATA_W-1:0]  csr_mepc,
  input  logic [DATA_W-1:0]  csr_mstatus,
  output logic               wr_en_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [DATA_W-1:0]  wr_data_o,
  output logic [INT_NUM-1:0] int_pending_o,
  output logic [INT_NUM-1:0] int_ack_o,
  output logic               clint_busy_o,
  output logic [ADDR_W-1:0]  int_addr_o,
  output logic               int_assert_o
);

  localparam logic [DATA_W-1:0] INS_ECALL =
    DATA_W'(32'h0000_0073);
  localparam logic [DATA_W-1:0] INS_EBREAK =
    DATA_W'(32'h0010_0073);
  localparam logic [DATA_W-1:0] INS_MRET =
    DATA_W'(32'h3020_0073);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MSTATUS,
    S_MCAUSE,
    S_ASSERT,
    S_MRET_ST,
    S_MRET_ASSERT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [INT_NUM-1:0] flag_q;
  logic [INT_NUM-1:0] pend;
  logic [INT_NUM-1:0] req;
  logic [INT_NUM-1:0] win_oh;
  logic [INT_NUM-1:0] ack_q;
  logic [3:0]         win;
  logic [3:0]         win_q;
  logic               async_q;
  logic [ADDR_W-1:0]  save_addr;
  logic [DATA_W-1:0]  cause_q;
  logic [DATA_W-1:0]  cause_async;
  logic [DATA_W-1:0]  ms_entry;
  logic [DATA_W-1:0]  ms_mret;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  target;

  logic idle;
  logic is_ecall;
  logic is_ebreak;
  logic is_mret;
  logic sync_trig;
  logic async_trig;
  logic mret_trig;
  logic unused_ok;

  assign idle      = (state == S_IDLE);
  assign is_ecall  = (ins_i == INS_ECALL);
  assign is_ebreak = (ins_i == INS_EBREAK);
  assign is_mret   = (ins_i == INS_MRET);
  assign req       = pend & int_mask_i;

  assign sync_trig  = idle & (is_ecall | is_ebreak);
  assign async_trig = idle & (|req) & csr_mstatus[3];
  assign mret_trig  = idle & is_mret;

  assign clint_busy_o  = ~idle | sync_trig
                       | async_trig | mret_trig;
  assign int_pending_o = pend;

  // lowest index wins
  always_comb begin
    win = '0;
    for (int k = INT_NUM - 1; k >= 0; k--) begin
      if (req[k]) win = 4'(k);
    end
  end

  assign win_oh = INT_NUM'(1) << win;

  always_comb begin
    cause_async = '0;
    cause_async[DATA_W-1] = 1'b1;
    cause_async[4:0] = {1'b1, win};
  end

  always_comb begin
    ms_entry    = csr_mstatus;
    ms_entry[7] = csr_mstatus[3];
    ms_entry[3] = 1'b0;
    ms_mret     = csr_mstatus;
    ms_mret[3]  = csr_mstatus[7];
    ms_mret[7]  = 1'b1;
  end

  assign base = {csr_mtvec[ADDR_W-1:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  assign target = (async_q && csr_mtvec[1:0] == 2'b01)
                ? base + ADDR_W'({1'b1, win_q, 2'b00})
                : base;
`else
  assign target = base;
`endif

  assign unused_ok = ^{csr_mtvec, win_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      flag_q    <= '0;
      pend      <= '0;
      ack_q     <= '0;
      win_q     <= '0;
      async_q   <= 1'b0;
      save_addr <= '0;
      cause_q   <= '0;
    end else begin
      state  <= state_nxt;
      flag_q <= int_flag_i;
      // a fresh edge beats a same-cycle ack
      pend   <= (pend & ~int_ack_o)
              | (int_flag_i & ~flag_q);
      if (sync_trig) begin
        async_q   <= 1'b0;
        ack_q     <= '0;
        save_addr <= ins_addr_i;
        cause_q   <= is_ebreak ? DATA_W'(3)
                               : DATA_W'(11);
      end else if (async_trig) begin
        async_q   <= 1'b1;
        ack_q     <= win_oh;
        win_q     <= win;
        save_addr <= restart_i
                   ? ins_addr_i - ADDR_W'(4)
                   : ins_addr_i;
        cause_q   <= cause_async;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (sync_trig || async_trig)
          state_nxt = S_MEPC;
        else if (mret_trig)
          state_nxt = S_MRET_ST;
      end
      S_MEPC:        state_nxt = S_MSTATUS;
      S_MSTATUS:     state_nxt = S_MCAUSE;
      S_MCAUSE:      state_nxt = S_ASSERT;
      S_ASSERT:      state_nxt = S_IDLE;
      S_MRET_ST:     state_nxt = S_MRET_ASSERT;
      S_MRET_ASSERT: state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en_o      = 1'b0;
    wr_addr_o    = '0;
    wr_data_o    = '0;
    int_ack_o    = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    unique case (state)
      S_MEPC: begin
        wr_en_o   = 1'b1;
        wr_addr_o = ADDR_W'(12'h341);
        wr_data_o = DATA_W'(save_addr);
        if (async_q) int_ack_o = ack_q;
      end
      S_MSTATUS: begin
        wr_en_o   = 1'b1;
        wr_addr_o = ADDR_W'(12'h300);
        wr_data_o = ms_entry;
      end
      S_MCAUSE: begin
        wr_en_o   = 1'b1;
        wr_addr_o = ADDR_W'(12'h342);
        wr_data_o = cause_q;
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = target;
      end
      S_MRET_ST: begin
        wr_en_o   = 1'b1;
        wr_addr_o = ADDR_W'(12'h300);
        wr_data_o = ms_mret;
      end
      S_MRET_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = ADDR_W'(csr_mepc);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_mi.sv
// tb_clint_mi: scoreboard bench for clint_mi.
// Expected CSR writes and redirects are queued; a monitor pops them.
`timescale 1ns/1ps
module tb_clint_mi;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef CLINT_VECTORED_EN
  localparam logic [31:0] VEC_TGT = 32'h1044;
`else
  localparam logic [31:0] VEC_TGT = 32'h1000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins;
  logic [31:0] ins_addr;
  logic        restart;
  logic [7:0]  flag;
  logic [7:0]  mask;
  logic [31:0] mtvec;
  logic [31:0] mepc_r;
  logic [31:0] mstatus_r;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  pend;
  logic [7:0]  ack;
  logic        busy;
  logic [31:0] iaddr;
  logic        as;

  typedef struct packed {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [7:0]  ack;
    logic        as;
    logic [31:0] ia;
  } rec_t;

  rec_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clint_mi #(
    .INT_NUM(8),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ins_i(ins),
    .ins_addr_i(ins_addr),
    .restart_i(restart),
    .int_flag_i(flag),
    .int_mask_i(mask),
    .csr_mtvec(mtvec),
    .csr_mepc(mepc_r),
    .csr_mstatus(mstatus_r),
    .wr_en_o(wr_en),
    .wr_addr_o(wr_addr),
    .wr_data_o(wr_data),
    .int_pending_o(pend),
    .int_ack_o(ack),
    .clint_busy_o(busy),
    .int_addr_o(iaddr),
    .int_assert_o(as)
  );

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic push_wr(input logic [31:0] wa,
                         input logic [31:0] wd,
                         input logic [7:0]  k);
    q.push_back('{we: 1'b1, wa: wa, wd: wd,
                  ack: k, as: 1'b0, ia: 32'h0});
  endtask

  task automatic push_as(input logic [31:0] ia);
    q.push_back('{we: 1'b0, wa: 32'h0, wd: 32'h0,
                  ack: 8'h0, as: 1'b1, ia: ia});
  endtask

  task automatic push_entry(input logic [31:0] a,
                            input logic [31:0] ms,
                            input logic [31:0] c,
                            input logic [7:0]  k,
                            input logic [31:0] tgt);
    push_wr(32'h341, a, k);
    push_wr(32'h300, ms, 8'h0);
    push_wr(32'h342, c, 8'h0);
    push_as(tgt);
  endtask

  // CSR file model: a write lands just after the clock edge
  task automatic tick();
    logic        en;
    logic [31:0] wa;
    logic [31:0] wd;
    @(negedge clk);
    en = wr_en;
    wa = wr_addr;
    wd = wr_data;
    @(posedge clk);
    #1;
    if (en && rst_n) begin
      if (wa == 32'h341) mepc_r = wd;
      else if (wa == 32'h300) mstatus_r = wd;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    rec_t e;
    rec_t act;
    if (rst_n && (wr_en || as || (|ack))) begin
      act = '{we: wr_en, wa: wr_addr, wd: wr_data,
              ack: ack, as: as, ia: iaddr};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %h expected none",
                 act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL seq_out: got we=%b a=%h d=%h ack=%h as=%b ia=%h expected we=%b a=%h d=%h ack=%h as=%b ia=%h",
                   act.we, act.wa, act.wd, act.ack, act.as, act.ia,
                   e.we, e.wa, e.wd, e.ack, e.as, e.ia);
        end
      end
    end
  end

  initial begin
    ins       = NOP;
    ins_addr  = 32'h0;
    restart   = 1'b0;
    flag      = 8'h00;
    mask      = 8'hFF;
    mtvec     = 32'h1000;
    mstatus_r = 32'h0;
    mepc_r    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_pending", 32'(pend), 32'h0);
    chk("rst_assert", 32'(as), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    mstatus_r = 32'h8;
    ticks(2);

    // ecall
    push_entry(32'h100, 32'h80, 32'd11, 8'h0, 32'h1000);
    ins = ECALL;
    ins_addr = 32'h100;
    #1;
    chk("ecall_busy_T", 32'(busy), 32'h1);
    tick();
    ins = NOP;
    for (int i = 1; i <= 4; i++) begin
      chk("ecall_busy_seq", 32'(busy), 32'h1);
      tick();
    end
    chk("ecall_busy_end", 32'(busy), 32'h0);

    // mret
    mepc_r = 32'h104;
    push_wr(32'h300, 32'h88, 8'h0);
    push_as(32'h104);
    ins = MRET;
    #1;
    chk("mret_busy_T", 32'(busy), 32'h1);
    tick();
    ins = NOP;
    ticks(2);
    chk("mret_busy_end", 32'(busy), 32'h0);
    chk("mret_mstatus", mstatus_r, 32'h88);

    // sources 2 and 5 together
    ins_addr = 32'h180;
    push_entry(32'h180, 32'h80, 32'h8000_0012,
               8'h04, 32'h1000);
    flag = 8'h24;
    tick();
    chk("dual_pending", 32'(pend), 32'h24);
    chk("dual_busy", 32'(busy), 32'h1);
    ticks(5);
    chk("dual_idle", 32'(busy), 32'h0);
    chk("dual_left", 32'(pend), 32'h20);

    // mret re-enables MIE, source 5 with restart
    push_wr(32'h300, 32'h88, 8'h0);
    push_as(32'h180);
    push_entry(32'h1FC, 32'h80, 32'h8000_0015,
               8'h20, 32'h1000);
    ins = MRET;
    ins_addr = 32'h200;
    restart = 1'b1;
    tick();
    ins = NOP;
    ticks(2);
    chk("src5_busy", 32'(busy), 32'h1);
    ticks(5);
    restart = 1'b0;
    chk("src5_pending", 32'(pend), 32'h0);
    chk("src5_idle", 32'(busy), 32'h0);

    // source 3 blocked by MIE=0, then by mask
    flag = 8'h2C;
    ticks(3);
    chk("mie0_pending", 32'(pend), 32'h08);
    chk("mie0_busy", 32'(busy), 32'h0);
    mask = 8'hF7;
    push_wr(32'h300, 32'h88, 8'h0);
    push_as(32'h1FC);
    ins = MRET;
    tick();
    ins = NOP;
    ticks(3);
    chk("mask_busy", 32'(busy), 32'h0);
    chk("mask_pending", 32'(pend), 32'h08);
    push_entry(32'h300, 32'h80, 32'h8000_0013,
               8'h08, 32'h1000);
    ins_addr = 32'h300;
    mask = 8'hFF;
    #1;
    chk("unmask_busy", 32'(busy), 32'h1);
    ticks(6);
    chk("src3_pending", 32'(pend), 32'h0);

    // ebreak, mtvec mode bits set
    mtvec = 32'h1001;
    push_entry(32'h400, 32'h00, 32'd3, 8'h0, 32'h1000);
    ins = EBREAK;
    ins_addr = 32'h400;
    tick();
    ins = NOP;
    ticks(5);
    chk("ebreak_mstatus", mstatus_r, 32'h0);

    // source 1 with vectored mtvec
    mstatus_r = 32'h8;
    ins_addr = 32'h500;
    push_entry(32'h500, 32'h80, 32'h8000_0011,
               8'h02, VEC_TGT);
    flag = 8'h2E;
    ticks(7);
    chk("src1_mepc", mepc_r, 32'h500);

    // reset mid-sequence
    mstatus_r = 32'h0;
    flag = 8'h2F;
    ticks(2);
    chk("pre_rst_pending", 32'(pend), 32'h01);
    push_wr(32'h341, 32'h600, 8'h0);
    ins = ECALL;
    ins_addr = 32'h600;
    tick();
    ins = NOP;
    tick();
    rst_n = 1'b0;
    flag = 8'h00;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'h0);
    chk("mid_rst_wr_data", wr_data, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_pending", 32'(pend), 32'h0);
    chk("mid_rst_assert", 32'(as), 32'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(3);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_pending", 32'(pend), 32'h0);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
